// File: rtl/tss_tx_scheduler.sv
// ============================================================================
// Module   : tss_tx_scheduler
// Function : Slice/frame/batch timing sequencer driving the TSS TX packetizer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tss_tx_scheduler #(
  parameter int TS_W    = 64,
  parameter int FIELD_W = 32,
  parameter int CMD_W   = 6*FIELD_W+TS_W+8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               timer_valid_i,
  input  logic [TS_W-1:0]    timer_i,
  input  logic [CMD_W-1:0]   command_i,
  output logic               busy_o,
  output logic [2:0]         state_o,
  output logic               slice_start_o,
  output logic               frame_start_o,
  output logic               batch_start_o,
  output logic [FIELD_W-1:0] slice_idx_o,
  output logic [FIELD_W-1:0] frame_idx_o,
  output logic [FIELD_W-1:0] batch_idx_o,
  output logic [FIELD_W-1:0] next_frame_o,
  output logic               seq_done_o,
  output logic               err_o
);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_ARMED  = 3'd1;
  localparam logic [2:0] c_RUN    = 3'd2;
  localparam logic [2:0] c_GAP    = 3'd3;
  localparam logic [2:0] c_PAUSED = 3'd4;

  localparam logic [7:0] c_OP_START = 8'h01;
  localparam logic [7:0] c_OP_STOP  = 8'h02;
  localparam logic [7:0] c_OP_CONT  = 8'h04;
  localparam logic [7:0] c_OP_ABORT = 8'h08;

  localparam logic [FIELD_W-1:0] c_ONE = FIELD_W'(1);

  // Command field unpacking, LSB first
  logic [7:0]         w_op;
  logic [TS_W-1:0]    w_time;
  logic [FIELD_W-1:0] w_slice_len, w_frame_len, w_batch_len, w_seq_len, w_interval, w_last_frame;

  assign w_op         = command_i[7:0];
  assign w_time       = command_i[8 +: TS_W];
  assign w_slice_len  = command_i[8+TS_W+0*FIELD_W +: FIELD_W];
  assign w_frame_len  = command_i[8+TS_W+1*FIELD_W +: FIELD_W];
  assign w_batch_len  = command_i[8+TS_W+2*FIELD_W +: FIELD_W];
  assign w_seq_len    = command_i[8+TS_W+3*FIELD_W +: FIELD_W];
  assign w_interval   = command_i[8+TS_W+4*FIELD_W +: FIELD_W];
  assign w_last_frame = command_i[8+TS_W+5*FIELD_W +: FIELD_W];

  logic [2:0]         r_state;
  logic [7:0]         r_op;
  logic [TS_W-1:0]    r_start_time, r_stop_time, r_cont_time;
  logic [FIELD_W-1:0] r_slice_len, r_frame_len, r_batch_len, r_seq_len, r_interval, r_last_frame;
  logic [FIELD_W-1:0] r_cyc, r_slice, r_frame, r_batch, r_next_frame;
  logic               r_stop_pend, r_stop_hit, r_cont_pend, r_resume_gap;
  logic               r_ss, r_fs, r_bs, r_done, r_err;

  logic               w_accept, w_zero_len;
  logic               w_run_tc, w_frame_end, w_batch_end, w_early, w_seq_end, w_gap_tc;
  logic               w_stop_now, w_arm_go, w_cont_go;
  logic [FIELD_W-1:0] w_nf_inc;
  logic [2:0]         w_ev_state, w_state_nxt;
  logic               w_err_nxt, w_capture, w_do_start, w_do_stop, w_do_cont, w_do_abort;
  logic               w_ss_nxt, w_fs_nxt, w_bs_nxt, w_done_nxt;

  assign w_accept   = (w_op != 8'h00) && ((r_op == 8'h00) || (w_op != r_op));
  assign w_zero_len = (w_slice_len == '0) || (w_frame_len == '0) ||
                      (w_batch_len == '0) || (w_seq_len == '0);

  // Terminal-count chain: compares precede increments so counters never wrap
  assign w_run_tc    = (r_state == c_RUN) && (r_cyc == r_slice_len - c_ONE);
  assign w_frame_end = w_run_tc && (r_slice == r_frame_len - c_ONE);
  assign w_batch_end = w_frame_end && (r_frame == r_batch_len - c_ONE);
  assign w_nf_inc    = r_next_frame + c_ONE;
  assign w_early     = w_frame_end && (r_last_frame != '0) && (w_nf_inc == r_last_frame);
  assign w_seq_end   = (w_batch_end && (r_batch == r_seq_len - c_ONE)) || w_early;
  assign w_gap_tc    = (r_state == c_GAP) && (r_cyc == r_interval - c_ONE);
  assign w_stop_now  = r_stop_pend && (r_stop_hit || (timer_i >= r_stop_time));
  assign w_arm_go    = (r_state == c_ARMED) && (timer_i >= r_start_time);
  assign w_cont_go   = (r_state == c_PAUSED) && r_cont_pend && (timer_i >= r_cont_time);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)             r_state <= c_IDLE;
    else if (!timer_valid_i) r_state <= c_IDLE;
    else                     r_state <= w_state_nxt;
  end

  // Timed events resolve first; a command accepted this cycle sees the post-event state
  always_comb begin
    w_ev_state = r_state;
    case (r_state)
      c_ARMED: begin
        if (w_stop_now)    w_ev_state = c_PAUSED;
        else if (w_arm_go) w_ev_state = c_RUN;
      end
      c_RUN: begin
        if (w_run_tc) begin
          if (w_seq_end)                                w_ev_state = c_IDLE;
          else if (w_stop_now)                          w_ev_state = c_PAUSED;
          else if (w_batch_end && (r_interval != '0))   w_ev_state = c_GAP;
        end
      end
      c_GAP:    if (w_gap_tc)  w_ev_state = w_stop_now ? c_PAUSED : c_RUN;
      c_PAUSED: if (w_cont_go) w_ev_state = r_resume_gap ? c_GAP : c_RUN;
      default:  w_ev_state = c_IDLE;
    endcase

    w_state_nxt = w_ev_state;
    w_err_nxt   = 1'b0;
    w_capture   = 1'b0;
    w_do_start  = 1'b0;
    w_do_stop   = 1'b0;
    w_do_cont   = 1'b0;
    w_do_abort  = 1'b0;
    if (w_accept) begin
      case (w_op)
        c_OP_START: begin
          if (w_ev_state == c_IDLE) begin
            w_capture = 1'b1;
            if (w_zero_len) begin
              w_err_nxt = 1'b1;
            end else begin
              w_do_start  = 1'b1;
              w_state_nxt = c_ARMED;
            end
          end else begin
            w_err_nxt = 1'b1;
          end
        end
        c_OP_STOP: begin
          if ((w_ev_state == c_ARMED) || (w_ev_state == c_RUN) || (w_ev_state == c_GAP))
            w_do_stop = 1'b1;
          else
            w_err_nxt = 1'b1;
        end
        c_OP_CONT: begin
          if (w_ev_state == c_PAUSED) w_do_cont = 1'b1;
          else                        w_err_nxt = 1'b1;
        end
        c_OP_ABORT: begin
          w_do_abort  = 1'b1;
          w_state_nxt = c_IDLE;
        end
        default: w_err_nxt = 1'b1;
      endcase
    end
  end

  always_comb begin
    w_ss_nxt = 1'b0;
    w_fs_nxt = 1'b0;
    w_bs_nxt = 1'b0;
    if (w_state_nxt == c_RUN) begin
      case (r_state)
        c_RUN: begin
          w_ss_nxt = w_run_tc;
          w_fs_nxt = w_frame_end;
          w_bs_nxt = w_batch_end;
        end
        c_PAUSED: begin
          w_ss_nxt = 1'b1;
          w_fs_nxt = (r_slice == '0);
          w_bs_nxt = (r_slice == '0) && (r_frame == '0);
        end
        default: begin
          w_ss_nxt = 1'b1;
          w_fs_nxt = 1'b1;
          w_bs_nxt = 1'b1;
        end
      endcase
    end
    w_done_nxt = w_seq_end && !w_do_abort;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) r_op <= 8'h00;
    else         r_op <= w_op;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n || !timer_valid_i) begin
      if (!arst_n || !timer_valid_i) begin
        r_start_time <= '0;  r_stop_time <= '0;  r_cont_time <= '0;
        r_slice_len  <= '0;  r_frame_len <= '0;  r_batch_len <= '0;
        r_seq_len    <= '0;  r_interval  <= '0;  r_last_frame <= '0;
        r_cyc        <= '0;  r_slice     <= '0;  r_frame      <= '0;
        r_batch      <= '0;  r_next_frame <= '0;
        r_stop_pend  <= 1'b0; r_stop_hit <= 1'b0; r_cont_pend <= 1'b0; r_resume_gap <= 1'b0;
        r_ss <= 1'b0; r_fs <= 1'b0; r_bs <= 1'b0; r_done <= 1'b0; r_err <= 1'b0;
      end
    end else begin
      r_err  <= w_err_nxt;
      r_ss   <= w_ss_nxt;
      r_fs   <= w_fs_nxt;
      r_bs   <= w_bs_nxt;
      r_done <= w_done_nxt;

      case (r_state)
        c_RUN: begin
          if (!w_run_tc) begin
            r_cyc <= r_cyc + c_ONE;
          end else begin
            r_cyc <= '0;
            if (w_seq_end) begin
              r_slice      <= '0;
              r_frame      <= '0;
              r_batch      <= '0;
              r_next_frame <= w_nf_inc;
            end else if (w_frame_end) begin
              r_slice      <= '0;
              r_next_frame <= w_nf_inc;
              if (w_batch_end) begin
                r_frame <= '0;
                r_batch <= r_batch + c_ONE;
              end else begin
                r_frame <= r_frame + c_ONE;
              end
            end else begin
              r_slice <= r_slice + c_ONE;
            end
          end
        end
        c_GAP:   r_cyc <= w_gap_tc ? '0 : r_cyc + c_ONE;
        default: ;
      endcase

      if (r_stop_pend && (timer_i >= r_stop_time)) r_stop_hit <= 1'b1;
      if (w_cont_go) r_cont_pend <= 1'b0;

      // A pause taken at a batch end owes the full inter-batch gap on resume
      if ((w_state_nxt == c_PAUSED) && (r_state != c_PAUSED)) begin
        r_stop_pend  <= 1'b0;
        r_stop_hit   <= 1'b0;
        r_resume_gap <= (r_state == c_RUN) && w_batch_end && (r_interval != '0);
      end

      if (w_state_nxt == c_IDLE) begin
        r_stop_pend  <= 1'b0;
        r_stop_hit   <= 1'b0;
        r_cont_pend  <= 1'b0;
        r_resume_gap <= 1'b0;
      end

      if (w_do_abort || w_do_start) begin
        r_cyc        <= '0;
        r_slice      <= '0;
        r_frame      <= '0;
        r_batch      <= '0;
        r_next_frame <= '0;
      end

      if (w_capture) begin
        r_start_time <= w_time;
        r_slice_len  <= w_slice_len;
        r_frame_len  <= w_frame_len;
        r_batch_len  <= w_batch_len;
        r_seq_len    <= w_seq_len;
        r_interval   <= w_interval;
        r_last_frame <= w_last_frame;
      end

      if (w_do_stop) begin
        r_stop_time <= w_time;
        r_stop_pend <= 1'b1;
        r_stop_hit  <= 1'b0;
      end

      if (w_do_cont) begin
        r_cont_time <= w_time;
        r_cont_pend <= 1'b1;
      end
    end
  end

  assign busy_o        = (r_state != c_IDLE);
  assign state_o       = r_state;
  assign slice_start_o = r_ss;
  assign frame_start_o = r_fs;
  assign batch_start_o = r_bs;
  assign slice_idx_o   = r_slice;
  assign frame_idx_o   = r_frame;
  assign batch_idx_o   = r_batch;
  assign next_frame_o  = r_next_frame;
  assign seq_done_o    = r_done;
  assign err_o         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tss_tx_scheduler.sv
// ============================================================================
// Module   : tb_tss_tx_scheduler
// Function : Directed self-checking bench for tss_tx_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tss_tx_scheduler;
  localparam int TS_W    = 64;
  localparam int FIELD_W = 32;
  localparam int CMD_W   = 6*FIELD_W+TS_W+8;

  localparam logic [7:0] c_START = 8'h01;
  localparam logic [7:0] c_STOP  = 8'h02;
  localparam logic [7:0] c_CONT  = 8'h04;
  localparam logic [7:0] c_ABORT = 8'h08;

  logic               clk = 1'b0;
  logic               arst_n = 1'b0;
  logic               timer_valid = 1'b1;
  logic [TS_W-1:0]    timer = '0;
  logic [CMD_W-1:0]   command = '0;
  logic               busy, slice_start, frame_start, batch_start, seq_done, err;
  logic [2:0]         state;
  logic [FIELD_W-1:0] slice_idx, frame_idx, batch_idx, next_frame;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tss_tx_scheduler #(.TS_W(TS_W), .FIELD_W(FIELD_W)) dut (
    .clk(clk), .arst_n(arst_n), .timer_valid_i(timer_valid), .timer_i(timer),
    .command_i(command), .busy_o(busy), .state_o(state),
    .slice_start_o(slice_start), .frame_start_o(frame_start), .batch_start_o(batch_start),
    .slice_idx_o(slice_idx), .frame_idx_o(frame_idx), .batch_idx_o(batch_idx),
    .next_frame_o(next_frame), .seq_done_o(seq_done), .err_o(err)
  );

  function automatic logic [CMD_W-1:0] mk(input logic [7:0] op, input logic [63:0] t,
      input logic [31:0] sl, input logic [31:0] fl, input logic [31:0] bl,
      input logic [31:0] sq, input logic [31:0] iv, input logic [31:0] lf);
    return {lf, iv, sq, bl, fl, sl, t, op};
  endfunction

  // After each tick, outputs belong to the cycle whose timer_i equals `timer`
  task automatic tick();
    @(posedge clk);
    #1;
    timer = timer + 64'd1;
  endtask

  task automatic wait_timer(input logic [63:0] t);
    int n = 0;
    while ((timer != t) && (n < 1000)) begin
      tick();
      n++;
    end
    if (timer != t) begin
      failures++;
      $error("FAIL timeout waiting for timer %0d: observed=%0d", t, timer);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ss", slice_start, 0);
    chk("rst_idx", slice_idx, 0);
    chk("rst_err", err, 0);
    arst_n = 1'b1;
    tick();

    // Zero gap
    timer = 90;
    command = mk(c_START, 100, 4, 2, 2, 1, 0, 0);
    tick();
    chk("t1_armed", state, 1);
    wait_timer(101);
    chk("t1_ss101", slice_start, 1);
    chk("t1_fs101", frame_start, 1);
    chk("t1_bs101", batch_start, 1);
    chk("t1_state101", state, 2);
    chk("t1_idx101", slice_idx, 0);
    tick();
    chk("t1_ss102", slice_start, 0);
    wait_timer(105);
    chk("t1_ss105", slice_start, 1);
    chk("t1_fs105", frame_start, 0);
    chk("t1_sidx105", slice_idx, 1);
    wait_timer(109);
    chk("t1_fs109", frame_start, 1);
    chk("t1_bs109", batch_start, 0);
    chk("t1_fidx109", frame_idx, 1);
    chk("t1_nf109", next_frame, 1);
    wait_timer(113);
    chk("t1_ss113", slice_start, 1);
    chk("t1_sidx113", slice_idx, 1);
    wait_timer(116);
    chk("t1_done116", seq_done, 0);
    chk("t1_busy116", busy, 1);
    tick();
    chk("t1_done117", seq_done, 1);
    chk("t1_state117", state, 0);
    chk("t1_nf117", next_frame, 2);
    chk("t1_fidx117", frame_idx, 0);
    tick();
    chk("t1_done118", seq_done, 0);
    chk("t1_busy118", busy, 0);
    command = '0;
    tick();

    // Batch gap
    timer = 90;
    command = mk(c_START, 100, 4, 2, 2, 2, 3, 0);
    tick();
    wait_timer(116);
    chk("t2_state116", state, 2);
    chk("t2_bidx116", batch_idx, 0);
    tick();
    chk("t2_state117", state, 3);
    chk("t2_bidx117", batch_idx, 1);
    chk("t2_ss117", slice_start, 0);
    wait_timer(119);
    chk("t2_state119", state, 3);
    tick();
    chk("t2_state120", state, 2);
    chk("t2_bs120", batch_start, 1);
    chk("t2_ss120", slice_start, 1);
    chk("t2_bidx120", batch_idx, 1);
    chk("t2_nf120", next_frame, 2);
    wait_timer(136);
    chk("t2_done136", seq_done, 1);
    chk("t2_nf136", next_frame, 4);
    chk("t2_state136", state, 0);
    command = '0;
    tick();

    // Early end on last_frame
    timer = 90;
    command = mk(c_START, 100, 2, 2, 4, 2, 0, 3);
    tick();
    wait_timer(112);
    chk("t3_fidx112", frame_idx, 2);
    chk("t3_done112", seq_done, 0);
    tick();
    chk("t3_done113", seq_done, 1);
    chk("t3_nf113", next_frame, 3);
    chk("t3_state113", state, 0);
    command = '0;
    tick();

    // Stop and resume
    timer = 90;
    command = mk(c_START, 100, 4, 4, 1, 1, 0, 0);
    tick();
    wait_timer(95);
    command = mk(c_STOP, 110, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_stop_err", err, 0);
    chk("t4_stop_state", state, 1);
    wait_timer(112);
    chk("t4_state112", state, 2);
    chk("t4_sidx112", slice_idx, 2);
    tick();
    chk("t4_state113", state, 4);
    chk("t4_sidx113", slice_idx, 3);
    chk("t4_ss113", slice_start, 0);
    wait_timer(120);
    command = mk(c_CONT, 200, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_cont_err", err, 0);
    chk("t4_state121", state, 4);
    wait_timer(200);
    chk("t4_state200", state, 4);
    tick();
    chk("t4_state201", state, 2);
    chk("t4_ss201", slice_start, 1);
    chk("t4_fs201", frame_start, 0);
    chk("t4_sidx201", slice_idx, 3);
    wait_timer(205);
    chk("t4_done205", seq_done, 1);
    chk("t4_nf205", next_frame, 1);
    command = '0;
    tick();
    command = mk(c_CONT, 300, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_cont_idle_err", err, 1);
    command = '0;
    tick();

    // Errors and holding
    command = mk(c_START, 100, 4, 0, 2, 1, 0, 0);
    tick();
    chk("t5_zero_err", err, 1);
    chk("t5_zero_state", state, 0);
    tick();
    chk("t5_zero_err_clr", err, 0);
    command = '0;
    tick();
    command = mk(c_START, 5000, 4, 2, 2, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_err", err, 0);
    end
    chk("t5_hold_state", state, 1);
    command = mk(8'h10, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_badop_err", err, 1);
    chk("t5_badop_state", state, 1);
    command = mk(c_START, 5000, 4, 2, 2, 1, 0, 0);
    tick();
    chk("t5_restart_err", err, 1);
    command = mk(c_ABORT, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_abort_armed", state, 0);
    command = '0;
    tick();
    timer = 90;
    command = mk(c_START, 100, 4, 2, 2, 1, 0, 0);
    tick();
    wait_timer(106);
    command = mk(c_ABORT, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("t5_abort_state", state, 0);
    chk("t5_abort_sidx", slice_idx, 0);
    chk("t5_abort_done", seq_done, 0);
    wait_timer(118);
    chk("t5_abort_nodone", seq_done, 0);
    chk("t5_abort_busy", busy, 0);
    command = '0;
    tick();

    // Reset mid-run
    timer = 90;
    command = mk(c_START, 100, 4, 2, 2, 1, 0, 0);
    tick();
    wait_timer(106);
    chk("t6_pre_sidx", slice_idx, 1);
    arst_n = 1'b0;
    #1;
    chk("t6_arst_state", state, 0);
    chk("t6_arst_busy", busy, 0);
    chk("t6_arst_sidx", slice_idx, 0);
    command = '0;
    tick();
    arst_n = 1'b1;
    tick();
    timer = 90;
    command = mk(c_START, 100, 4, 2, 2, 1, 0, 0);
    tick();
    wait_timer(106);
    chk("t6_pre2_state", state, 2);
    timer_valid = 1'b0;
    tick();
    chk("t6_tv_state", state, 0);
    chk("t6_tv_busy", busy, 0);
    chk("t6_tv_sidx", slice_idx, 0);
    chk("t6_tv_done", seq_done, 0);
    timer_valid = 1'b1;
    command = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
